uart_tx_frame: RTL and testbench

//  Serialises one parallel word into a UART frame for the TX line.
//  - Frame order: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
//  - Consumes parity_bit from uart_tx_parity, which sits directly upstream and shares data_valid/parallel_data.
//  - The internal bit-period counter sets bit timing; no external baud tick is needed.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_frame_if.sv | 25 ++
 rtl/uart_bit_timer.sv | 26 ++
 rtl/uart_tx_frame.sv | 131 +++++++++++++
 tb/tb_uart_tx_frame.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding,
// default bit timing and the fixed line levels used in a frame.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int   DEFAULT_CLKS_PER_BIT = 434;
  localparam logic LINE_IDLE            = 1'b1;
  localparam logic START_BIT            = 1'b0;
  localparam logic STOP_BIT             = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word-in / line-out bundle between the upstream parity stage, the
// frame serialiser and whatever consumes its status flags.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] parallel_data;
  logic                  parity_en;
  logic                  parity_bit;
  logic                  tx_serial;
  logic                  tx_ready;
  logic                  tx_busy;
  logic                  tx_done;
  logic                  tx_overrun;

  modport master (
    output data_valid, parallel_data, parity_en, parity_bit,
    input  tx_serial, tx_ready, tx_busy, tx_done, tx_overrun
  );

  modport slave (
    input  data_valid, parallel_data, parity_en, parity_bit,
    output tx_serial, tx_ready, tx_busy, tx_done, tx_overrun
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: o_bit_end is high during the last cycle of each
// CLKS_PER_BIT-cycle period; i_clear holds the count at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic UCLK,
  input  logic reset,
  input  logic i_clear,
  output logic o_bit_end
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, LSB-first data, optional upstream
// parity bit and one or two stop bits on a registered TX line.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic            UCLK,
  input  logic            reset,
  uart_tx_frame_if.slave  bus
);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  uart_state_t           r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic                  r_par_en, w_par_en_next;
  logic                  r_line, w_line_next;
  logic                  r_done, w_done_next;
  logic                  r_overrun, w_overrun_next;
  logic                  w_bit_end;
  logic                  w_timer_clear;

  // Holding the timer at zero in IDLE makes the accept edge the start of bit 0.
  assign w_timer_clear = (r_state == S_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .UCLK      (UCLK),
    .reset     (reset),
    .i_clear   (w_timer_clear),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      r_par_en  <= 1'b0;
      r_line    <= LINE_IDLE;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_idx     <= w_idx_next;
      r_par_en  <= w_par_en_next;
      r_line    <= w_line_next;
      r_done    <= w_done_next;
      r_overrun <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_idx_next     = r_idx;
    w_par_en_next  = r_par_en;
    w_line_next    = r_line;
    w_done_next    = 1'b0;
    w_overrun_next = bus.data_valid && (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (bus.data_valid) begin
          w_state_next  = S_START;
          w_shift_next  = bus.parallel_data;
          w_par_en_next = bus.parity_en;
          w_idx_next    = '0;
          w_line_next   = START_BIT;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_idx_next   = '0;
          w_line_next  = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == IDX_W'(DATA_WIDTH - 1)) begin
            w_idx_next = '0;
            if (r_par_en) begin
              w_state_next = S_PARITY;
              w_line_next  = bus.parity_bit;
            end else begin
              w_state_next = S_STOP;
              w_line_next  = STOP_BIT;
            end
          end else begin
            w_idx_next   = r_idx + IDX_W'(1);
            w_shift_next = r_shift >> 1;
            w_line_next  = w_shift_next[0];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_idx_next   = '0;
          w_line_next  = STOP_BIT;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_idx == IDX_W'(STOP_BITS - 1)) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
            w_line_next  = LINE_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_line_next  = LINE_IDLE;
      end
    endcase
  end

  assign bus.tx_serial  = r_line;
  assign bus.tx_ready   = (r_state == S_IDLE);
  assign bus.tx_busy    = (r_state != S_IDLE);
  assign bus.tx_done    = r_done;
  assign bus.tx_overrun = r_overrun;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomised frame checks for uart_tx_frame against a
// bit-list model of the frame; dut2 covers the two-stop-bit variant.
module tb_uart_tx_frame;
  localparam int C  = 4;
  localparam int DW = 8;

  logic UCLK  = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 UCLK = ~UCLK;

  uart_tx_frame_if #(.DATA_WIDTH(DW)) bus1 ();
  uart_tx_frame_if #(.DATA_WIDTH(DW)) bus2 ();

  assign bus2.data_valid    = bus1.data_valid;
  assign bus2.parallel_data = bus1.parallel_data;
  assign bus2.parity_en     = bus1.parity_en;
  assign bus2.parity_bit    = bus1.parity_bit;

  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .UCLK  (UCLK),
    .reset (reset),
    .bus   (bus1.slave)
  );

  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .UCLK  (UCLK),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // {serial, ready, busy, done, overrun}
  function automatic logic [4:0] outs(input int sel);
    if (sel == 2)
      return {bus2.tx_serial, bus2.tx_ready, bus2.tx_busy, bus2.tx_done, bus2.tx_overrun};
    return {bus1.tx_serial, bus1.tx_ready, bus1.tx_busy, bus1.tx_done, bus1.tx_overrun};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    logic [4:0] o;
    o = outs(sel);
    check({tag, " serial"},  {7'd0, o[4]}, 8'd1);
    check({tag, " ready"},   {7'd0, o[3]}, 8'd1);
    check({tag, " busy"},    {7'd0, o[2]}, 8'd0);
    check({tag, " done"},    {7'd0, o[1]}, 8'd0);
    check({tag, " overrun"}, {7'd0, o[0]}, 8'd0);
  endtask

  // Sends one word and checks every cycle of the frame against the
  // expected bit list. Entry and exit are 1 ns after a rising edge.
  task automatic run_frame(input int sel, input logic [7:0] data, input logic pen,
                           input logic pbit, input int stop_bits, input bit hold,
                           input bit scramble, input int rst_at, input string name);
    logic exp_q[$];
    logic [4:0] o;
    int n;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(data[i]);
    if (pen) exp_q.push_back(pbit);
    for (int i = 0; i < stop_bits; i++) exp_q.push_back(1'b1);
    n = exp_q.size() * C;

    bus1.parallel_data = data;
    bus1.parity_en     = pen;
    bus1.data_valid    = 1'b1;
    @(posedge UCLK); #1;
    if (!hold) bus1.data_valid = 1'b0;
    bus1.parity_bit = pbit;

    for (int t = 0; t < n; t++) begin
      if (t == rst_at) begin
        #2 reset = 1'b0;
        #1 check_idle(sel, $sformatf("%s async-reset t=%0d", name, t));
        @(negedge UCLK) reset = 1'b1;
        @(posedge UCLK); #1;
        $display("frame %s: reset at cycle %0d", name, t);
        return;
      end
      o = outs(sel);
      check($sformatf("%s serial t=%0d", name, t),  {7'd0, o[4]}, {7'd0, exp_q[t / C]});
      check($sformatf("%s ready t=%0d", name, t),   {7'd0, o[3]}, 8'd0);
      check($sformatf("%s busy t=%0d", name, t),    {7'd0, o[2]}, 8'd1);
      check($sformatf("%s done t=%0d", name, t),    {7'd0, o[1]}, 8'd0);
      check($sformatf("%s overrun t=%0d", name, t), {7'd0, o[0]},
            {7'd0, (hold && t >= 1)});
      if (scramble) begin
        bus1.parallel_data = 8'($urandom);
        bus1.parity_en     = 1'($urandom);
      end
      @(posedge UCLK); #1;
    end

    o = outs(sel);
    check({name, " done at end"},    {7'd0, o[1]}, 8'd1);
    check({name, " ready at end"},   {7'd0, o[3]}, 8'd1);
    check({name, " busy at end"},    {7'd0, o[2]}, 8'd0);
    check({name, " serial at end"},  {7'd0, o[4]}, 8'd1);
    check({name, " overrun at end"}, {7'd0, o[0]}, {7'd0, hold});
    $display("frame %s: data=%02h pen=%0b pbit=%0b stops=%0d cycles=%0d", name, data, pen,
             pbit, stop_bits, n);
  endtask

  task automatic pulse_reset();
    @(negedge UCLK) reset = 1'b0;
    @(negedge UCLK) reset = 1'b1;
    @(posedge UCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       p;
    bus1.data_valid    = 1'b0;
    bus1.parallel_data = '0;
    bus1.parity_en     = 1'b0;
    bus1.parity_bit    = 1'b0;

    repeat (3) @(posedge UCLK);
    #1;
    check_idle(1, "reset dut1");
    check_idle(2, "reset dut2");
    @(negedge UCLK) reset = 1'b1;
    @(posedge UCLK); #1;
    check_idle(1, "after release");

    run_frame(1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, -1, "a5");
    run_frame(1, 8'h55, 1'b1, 1'b1, 1, 1'b0, 1'b0, -1, "55par");
    run_frame(1, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b0, -1, "hold1");
    run_frame(1, 8'hC3, 1'b1, 1'b0, 1, 1'b0, 1'b0, -1, "hold2");
    @(posedge UCLK); #1;
    check_idle(1, "idle after hold");

    run_frame(1, 8'h96, 1'b0, 1'b0, 1, 1'b0, 1'b0, 13, "rst");
    check_idle(1, "idle after reset");
    run_frame(1, 8'h0F, 1'b0, 1'b0, 1, 1'b0, 1'b0, -1, "0f");

    pulse_reset();
    run_frame(2, 8'hFF, 1'b1, 1'b0, 2, 1'b0, 1'b0, -1, "stop2");
    pulse_reset();

    run_frame(1, 8'h6B, 1'b1, 1'b1, 1, 1'b0, 1'b1, -1, "scramble");
    bus1.parity_en = 1'b0;

    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      run_frame(1, d, p, ~^d, 1, 1'b0, 1'b0, -1, $sformatf("rand%0d", k));
      repeat ($urandom_range(0, 3)) @(posedge UCLK);
      #0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
